id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode/operand stage directly upstream of the ALU: accepts one RV32I instruction (OP, OP-IMM, LUI, AUIPC), reads rs1/rs2 from an internal 32x32 register file, and produces registered ALU operands a, b plus an alu_op code.
- Writeback port from the downstream stage updates the register file.
- Valid/ready pipeline register on the output supports backpressure and flush.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, register count (x0 hardwired zero)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept an instruction
- instr  in  32  RV32I instruction word
- pc  in  XLEN  instruction address (for AUIPC)
- flush  in  1  discard the held and incoming instruction
- wb_en  in  1  register write enable
- wb_rd  in  5  write address
- wb_data  in  XLEN  write data
- out_valid  out  1  operands valid to ALU
- out_ready  in  1  ALU accepts operands
- a  out  XLEN  ALU operand A
- b  out  XLEN  ALU operand B
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- rd  out  5  destination register
- rd_we  out  1  result to be written back
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, all registers 0; reset takes priority over every other input.
- in_ready = !out_valid || out_ready. This path is combinational.
- Transfer: when in_valid && in_ready && !flush, the output register loads on the next edge and out_valid=1. Latency is 1 cycle.
- Hold: when out_valid && !out_ready, a/b/alu_op/rd/rd_we/illegal/out_valid stay stable.
- Pop without refill: out_valid drops to 0 next cycle.
- flush=1: out_valid=0 next cycle regardless of in_valid/out_ready. The incoming instruction is dropped.
- OP (0110011):
  - a=R[rs1], b=R[rs2], op selected by funct3 plus instr[30].
  - funct7 other than 0000000, or 0100000 with ADD/SRL, is illegal.
- OP-IMM (0010011):
  - a=R[rs1], b=sign-extended imm[11:0].
  - SLLI/SRLI/SRAI: b=zero-extended shamt[4:0]; funct7 must be 0000000, or 0100000 for SRAI only, otherwise illegal.
- LUI: a=0, b={instr[31:12],12'b0}, ADD.
- AUIPC: a=pc, b={instr[31:12],12'b0}, ADD.
- Illegal (any other opcode or bad funct7): illegal=1, rd_we=0, a=b=0, alu_op=ADD. The instruction still transfers with out_valid=1.
- rd_we=1 for every legal instruction with rd!=0. rd_we=0 when rd=0.
- Register file:
  - Written on clk edge when wb_en && wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Writeback is independent of handshake/flush state.

Optional Feature:
- Macro: IDEX_WB_BYPASS_EN
- Defined: a same-cycle writeback whose wb_rd equals rs1/rs2 (nonzero) supplies wb_data as the operand, i.e. write-through read.
- Undefined: reads return the pre-write register value. Hazard avoidance then belongs to the issuer.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC)
  - alu_op_t with the 4-bit encodings above, shared with the ALU
  - funct3 constants
  - XLEN
- One sub-module, regfile_2r1w: 2 combinational read ports, 1 synchronous write, x0 zero, bypass under IDEX_WB_BYPASS_EN.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, a=0, b=5, alu_op=0, rd=1, rd_we=1, illegal=0.
- wb_en=1, wb_rd=2, wb_data=0x1234 in the same cycle as ADD x3,x2,x2 (0x002101B3) -> a=b=0x1234 with IDEX_WB_BYPASS_EN, a=b=0 without. The next ADD reads 0x1234 in both builds.
- out_ready=0 for 3 cycles with a second instruction pending -> in_ready=0, outputs frozen. out_ready=1 -> second instruction appears the following cycle, nothing lost or duplicated.
- LUI x5,0xABCDE (0xABCDE2B7) -> a=0, b=0xABCDE000, rd=5. AUIPC x6,1 (0x00001317) at pc=0x100 -> a=0x100, b=0x1000.
- SRAI x4,x1,3 (0x4030D213) -> alu_op=7, b=3. Then 0x0000007F -> illegal=1, rd_we=0.
- flush=1 with in_valid=1 while holding a stalled output -> out_valid=0 next cycle. wb write to x0 with 0xFFFFFFFF, then ADD x7,x0,x0 -> a=b=0. rst_n=0 mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I decode constants and the ALU operation
//                encoding used by the operand stage and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Datapath width shared by the decode stage and the ALU
    localparam int XLEN = 32;

    // Major opcodes handled by the operand stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values that are legal for OP / shift-immediate encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // ALU operation encoding, fixed by the ALU interface
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Map funct3 plus the alternate bit (instr[30]) onto an ALU operation.
    // The caller decides whether the alternate bit is meaningful.
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Integer register file with two combinational read ports
//                and one synchronous write port. x0 reads as zero and
//                ignores writes.
//  Options     : IDEX_WB_BYPASS_EN - a read that hits the register being
//                written in the same cycle returns the write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

`ifdef IDEX_WB_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr;

    // x0 is never written so its storage stays at the reset value of zero
    assign w_wr = i_wb_en && (i_wb_rd != 5'd0) && (int'(i_wb_rd) < NREG);

    // Storage update: clear everything on reset, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // Read ports: x0 and out-of-range addresses read zero, optional write-through
    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if ((i_rs1 != 5'd0) && (int'(i_rs1) < NREG)) begin
            if (c_BYPASS && w_wr && (i_wb_rd == i_rs1)) begin
                o_rs1_data = i_wb_data;
            end else begin
                o_rs1_data = r_regs[i_rs1];
            end
        end
        if ((i_rs2 != 5'd0) && (int'(i_rs2) < NREG)) begin
            if (c_BYPASS && w_wr && (i_wb_rd == i_rs2)) begin
                o_rs2_data = i_wb_data;
            end else begin
                o_rs2_data = r_regs[i_rs2];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : RV32I decode/operand stage feeding the ALU. Decodes OP,
//                OP-IMM, LUI and AUIPC, reads rs1/rs2 from the internal
//                register file and presents registered operands behind a
//                valid/ready pipeline register with flush.
//  Options     : IDEX_WB_BYPASS_EN - same-cycle writeback forwards into
//                the operand reads (handled in regfile_2r1w).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_op,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;

    // Register file read data
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // Decode results
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    alu_op_t         w_alu_op;
    logic            w_illegal;
    logic            w_rd_we;
    logic            w_load;

    // Pipeline register
    logic            r_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    alu_op_t         r_alu_op;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic            r_illegal;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_f3     = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_f7     = instr[31:25];
    assign w_imm_i  = XLEN'($signed(instr[31:20]));
    assign w_imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign w_shamt  = XLEN'(instr[24:20]);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    // Decode: start from the illegal result (zero operands, ADD) and override on a legal match
    always_comb begin
        w_illegal = 1'b1;
        w_alu_op  = ALU_ADD;
        w_a       = '0;
        w_b       = '0;
        case (w_opcode)
            OPC_OP: begin
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form
                if ((w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR)))) begin
                    w_illegal = 1'b0;
                    w_alu_op  = f3_to_alu(w_f3, instr[30]);
                    w_a       = w_rs1_data;
                    w_b       = w_rs2_data;
                end
            end
            OPC_OP_IMM: begin
                case (w_f3)
                    F3_SLL: begin
                        if (w_f7 == F7_BASE) begin
                            w_illegal = 1'b0;
                            w_alu_op  = ALU_SLL;
                            w_a       = w_rs1_data;
                            w_b       = w_shamt;
                        end
                    end
                    F3_SR: begin
                        if ((w_f7 == F7_BASE) || (w_f7 == F7_ALT)) begin
                            w_illegal = 1'b0;
                            w_alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
                            w_a       = w_rs1_data;
                            w_b       = w_shamt;
                        end
                    end
                    default: begin
                        // instr[30] is part of the immediate here, never SUB
                        w_illegal = 1'b0;
                        w_alu_op  = f3_to_alu(w_f3, 1'b0);
                        w_a       = w_rs1_data;
                        w_b       = w_imm_i;
                    end
                endcase
            end
            OPC_LUI: begin
                w_illegal = 1'b0;
                w_b       = w_imm_u;
            end
            OPC_AUIPC: begin
                w_illegal = 1'b0;
                w_a       = pc;
                w_b       = w_imm_u;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_rd_we  = !w_illegal && (w_rd != 5'd0);
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // Output pipeline register: reset, then flush, then load, then pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_op  <= ALU_ADD;
            r_rd      <= 5'd0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_a       <= w_a;
            r_b       <= w_b;
            r_alu_op  <= w_alu_op;
            r_rd      <= w_rd;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign alu_op    = r_alu_op;
    assign rd        = r_rd;
    assign rd_we     = r_rd_we;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: directed scenarios
//                followed by randomized traffic against a reference model.
//  Options     : IDEX_WB_BYPASS_EN - selects the write-through expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        m_ill;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Operand value seen by a decode in the current cycle
    function automatic logic [31:0] rd_port(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef IDEX_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    // Mnemonic-level reference decode
    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                              input logic [31:0] r1, input logic [31:0] r2,
                              output logic [31:0] ea, output logic [31:0] eb,
                              output logic [3:0] eop, output logic ewe, output logic eill);
        logic [3:0]  tbl [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] uimm;
        logic [31:0] sh;
        tbl  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        imm  = {{20{ins[31]}}, ins[31:20]};
        uimm = {ins[31:12], 12'h000};
        sh   = {27'd0, ins[24:20]};
        eill = 1'b1; eop = 4'd0; ea = 32'd0; eb = 32'd0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                eill = 1'b0; eop = tbl[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                eill = 1'b0; eop = 4'd1;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                eill = 1'b0; eop = 4'd7;
            end
            if (!eill) begin ea = r1; eb = r2; end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) begin eill = 1'b0; eop = 4'd2; eb = sh; end
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00)      begin eill = 1'b0; eop = 4'd6; eb = sh; end
                else if (f7 == 7'h20) begin eill = 1'b0; eop = 4'd7; eb = sh; end
            end else begin
                eill = 1'b0; eop = tbl[f3]; eb = imm;
            end
            if (!eill) ea = r1;
        end else if (opc == 7'h37) begin
            eill = 1'b0; eb = uimm;
        end else if (opc == 7'h17) begin
            eill = 1'b0; ea = pcv; eb = uimm;
        end
        ewe = !eill && (ins[11:7] != 5'd0);
    endtask

    // One clock cycle with the currently driven inputs, model update and output check
    task automatic step();
        logic [31:0] ea, eb;
        logic [3:0]  eop;
        logic        ewe, eill, exp_ready;
        #1;
        exp_ready = !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        ref_decode(instr, pc, rd_port(instr[19:15]), rd_port(instr[24:20]), ea, eb, eop, ewe, eill);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 4'd0;
            m_rd = 5'd0; m_we = 1'b0; m_ill = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_ready) begin
                m_valid = 1'b1; m_a = ea; m_b = eb; m_op = eop;
                m_rd = instr[11:7]; m_we = ewe; m_ill = eill;
            end else if (out_ready) m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (!rst_n) begin
            check("rst_a", a, 32'd0);
            check("rst_b", b, 32'd0);
            check("rst_op", 32'(alu_op), 32'd0);
            check("rst_rd", 32'(rd), 32'd0);
            check("rst_we", 32'(rd_we), 32'd0);
            check("rst_ill", 32'(illegal), 32'd0);
        end else if (m_valid) begin
            check("a", a, m_a);
            check("b", b, m_b);
            check("alu_op", 32'(alu_op), 32'(m_op));
            check("rd_we", 32'(rd_we), 32'(m_we));
            check("illegal", 32'(illegal), 32'(m_ill));
            if (!m_ill) check("rd", 32'(rd), 32'(m_rd));
        end
    endtask

    function automatic logic [6:0] pick_f7();
        int s;
        s = $urandom_range(0, 5);
        if (s <= 2) return 7'h00;
        if (s <= 4) return 7'h20;
        return 7'($urandom);
    endfunction

    function automatic logic [31:0] gen_instr();
        int          kind;
        logic [31:0] w;
        logic [2:0]  f3;
        kind = $urandom_range(0, 9);
        w    = $urandom;
        f3   = w[14:12];
        if (kind <= 2) begin
            w = {pick_f7(), w[24:7], 7'h33};
        end else if (kind <= 5) begin
            if (f3 == 3'd1 || f3 == 3'd5) w = {pick_f7(), w[24:7], 7'h13};
            else                          w = {w[31:7], 7'h13};
        end else if (kind == 6) begin
            w = {w[31:7], 7'h37};
        end else if (kind == 7) begin
            w = {w[31:7], 7'h17};
        end
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // ADDI x1,x0,5
        in_valid = 1'b1; instr = 32'h00500093;
        step();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_a", a, 32'd0);
        check("addi_b", b, 32'd5);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_we", 32'(rd_we), 32'd1);

        // ADD x3,x2,x2 with same-cycle writeback of x2
        instr = 32'h002101B3; wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234;
        step();
`ifdef IDEX_WB_BYPASS_EN
        check("wb_same_a", a, 32'h1234);
`else
        check("wb_same_a", a, 32'h0);
`endif
        wb_en = 1'b0;
        step();
        check("wb_next_b", b, 32'h1234);

        // Backpressure: hold ADDI x2,x0,10 while ADD x3,x1,x2 waits
        instr = 32'h00A00113;
        step();
        out_ready = 1'b0; instr = 32'h002081B3;
        repeat (3) step();
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_b", b, 32'd10);
        out_ready = 1'b1;
        step();
        check("stall_rd", 32'(rd), 32'd3);
        in_valid = 1'b0;
        step();
        check("pop_valid", 32'(out_valid), 32'd0);

        // LUI / AUIPC
        in_valid = 1'b1; instr = 32'hABCDE2B7;
        step();
        check("lui_b", b, 32'hABCDE000);
        instr = 32'h00001317; pc = 32'h100;
        step();
        check("auipc_a", a, 32'h100);
        check("auipc_b", b, 32'h1000);

        // SRAI then an unknown opcode
        instr = 32'h4030D213;
        step();
        check("srai_op", 32'(alu_op), 32'd7);
        check("srai_b", b, 32'd3);
        instr = 32'h0000007F;
        step();
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_we", 32'(rd_we), 32'd0);

        // Flush while holding a stalled output
        instr = 32'h00500093;
        step();
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Writes to x0 are ignored
        in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h000003B3;
        step();
        check("x0_a", a, 32'd0);
        check("x0_b", b, 32'd0);

        // Reset in the middle of a stall
        out_ready = 1'b0; instr = 32'h00500093;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = gen_instr();
            pc        = $urandom;
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom);
            if ($urandom_range(0, 3) == 0) wb_rd = instr[19:15];
            wb_data   = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
